// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeder.
//   - default geometry of the 3x3 array and element width
//   - feeder state encoding
//   - write-port address width and feed-length helper
package systolic_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int ROW_DEF         = 3;
    localparam int COL_DEF         = 3;
    localparam int NUM_DEF         = 3;
    localparam int DRAIN_EXTRA_DEF = 2;

    // Write address covers r*NUM+k (A) or k*COL+c (B); 4 bits spans the 3x3 case.
    localparam int ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of FEED cycles: the last skewed element leaves at
    // NUM+max(ROW,COL)-2, then the PE pipeline drains and the far column settles.
    function automatic int feed_len(int num, int row, int col, int drain);
        return num + ((row > col) ? row : col) - 1 + drain + (col - 1);
    endfunction

endpackage

// File: rtl/skew_sel.sv
// Per-lane skew selector (combinational).
//   lane : lane index (row i or column j), i.e. its delay in cycles
//   t    : feed step
//   vec  : the NUM elements this lane streams, element k at vec[k]
//   elem : vec[t-lane] when 0 <= t-lane < NUM, otherwise 0
module skew_sel
    import systolic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NUM    = NUM_DEF,
    parameter int CNT_W  = 4
) (
    input  logic [CNT_W-1:0]           lane,
    input  logic [CNT_W-1:0]           t,
    input  logic [NUM-1:0][DATA_W-1:0] vec,
    output logic [DATA_W-1:0]          elem
);

    // Compare t against lane+k rather than subtracting, so no underflow
    // handling is needed for steps before the lane's first element.
    always_comb begin
        elem = '0;
        for (int k = 0; k < NUM; k++) begin
            if ({1'b0, t} == ({1'b0, lane} + (CNT_W + 1)'(k)))
                elem = vec[k];
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Skewed operand feeder for the 3x3 output-stationary systolic MAC array.
// Holds one A (ROW x NUM) and one B (NUM x COL) matrix loaded via a write
// port; on start streams row i of A delayed by i cycles and column j of B
// delayed by j cycles, with a per-row first-element tag.
//   clk, rst_n           : clock, asynchronous active-low reset
//   wr_en/wr_sel/wr_addr : element write (sel 0 = A at r*NUM+k, 1 = B at k*COL+c)
//   wr_data              : signed element
//   start                : begin a feed sequence (only accepted in IDLE)
//   busy, done           : sequence in progress / one-cycle end pulse
//   din_r1..3, din_c1..3 : registered row / column streams
//   in_tag_new           : bit i high on row i's first element
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ROW         = ROW_DEF,
    parameter int COL         = COL_DEF,
    parameter int NUM         = NUM_DEF,
    parameter int DRAIN_EXTRA = DRAIN_EXTRA_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] din_r1,
    output logic [DATA_W-1:0] din_r2,
    output logic [DATA_W-1:0] din_r3,
    output logic [DATA_W-1:0] din_c1,
    output logic [DATA_W-1:0] din_c2,
    output logic [DATA_W-1:0] din_c3,
    output logic [ROW-1:0]    in_tag_new
);

    localparam int L     = feed_len(NUM, ROW, COL, DRAIN_EXTRA);
    localparam int CNT_W = $clog2(L + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] t_q, t_d;
    logic             feed_d;
    logic             wr_ok;

    logic [ROW-1:0][NUM-1:0][DATA_W-1:0] a_mem;
    logic [NUM-1:0][COL-1:0][DATA_W-1:0] b_mem;
    logic [COL-1:0][NUM-1:0][DATA_W-1:0] col_vec;

    logic [ROW-1:0][DATA_W-1:0] row_sel, row_q;
    logic [COL-1:0][DATA_W-1:0] col_sel, col_q;
    logic [ROW-1:0]             tag_q;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    // A simultaneous write wins over start: the write lands, start is dropped.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        case (state_q)
            IDLE: begin
                if (start && !wr_en) begin
                    state_d = FEED;
                    t_d     = '0;
                end
            end
            FEED: begin
                if (t_q == CNT_W'(L - 1)) begin
                    state_d = DONE;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy   = (state_q == FEED);
    assign done   = (state_q == DONE);
    assign feed_d = (state_d == FEED);
    assign wr_ok  = wr_en && (state_q == IDLE);

    // ---------------- matrix storage ----------------
    // Addresses past the last element match no slot and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_mem <= '0;
            b_mem <= '0;
        end else if (wr_ok) begin
            for (int r = 0; r < ROW; r++)
                for (int k = 0; k < NUM; k++)
                    if (!wr_sel && wr_addr == ADDR_W'(r * NUM + k))
                        a_mem[r][k] <= wr_data;
            for (int k = 0; k < NUM; k++)
                for (int c = 0; c < COL; c++)
                    if (wr_sel && wr_addr == ADDR_W'(k * COL + c))
                        b_mem[k][c] <= wr_data;
        end
    end

    // Transpose B so each column lane sees its NUM elements as one vector.
    always_comb begin
        col_vec = '0;
        for (int c = 0; c < COL; c++)
            for (int k = 0; k < NUM; k++)
                col_vec[c][k] = b_mem[k][c];
    end

    // ---------------- skew lanes ----------------
    // Lanes select on the next step t_d so the registered outputs show step t
    // in the t-th cycle after the accept edge.
    for (genvar gi = 0; gi < ROW; gi++) begin : g_row
        skew_sel #(.DATA_W(DATA_W), .NUM(NUM), .CNT_W(CNT_W)) u_sel (
            .lane (CNT_W'(gi)),
            .t    (t_d),
            .vec  (a_mem[gi]),
            .elem (row_sel[gi])
        );
    end

    for (genvar gj = 0; gj < COL; gj++) begin : g_col
        skew_sel #(.DATA_W(DATA_W), .NUM(NUM), .CNT_W(CNT_W)) u_sel (
            .lane (CNT_W'(gj)),
            .t    (t_d),
            .vec  (col_vec[gj]),
            .elem (col_sel[gj])
        );
    end

    // ---------------- output registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
            tag_q <= '0;
        end else begin
            for (int r = 0; r < ROW; r++) begin
                row_q[r] <= feed_d ? row_sel[r] : '0;
                tag_q[r] <= feed_d && (t_d == CNT_W'(r));
            end
            for (int c = 0; c < COL; c++)
                col_q[c] <= feed_d ? col_sel[c] : '0;
        end
    end

    assign din_r1     = row_q[0];
    assign din_r2     = row_q[1];
    assign din_r3     = row_q[2];
    assign din_c1     = col_q[0];
    assign din_c2     = col_q[1];
    assign din_c3     = col_q[2];
    assign in_tag_new = tag_q;

endmodule
